// File: rtl/rsa_ctrl_pkg.sv
// Shared types and default parameters for the RSA CPU run controller.
package rsa_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_RST,
        ARM,
        WAIT_END,
        DONE,
        ABORT_RST
    } run_state_t;

    localparam int unsigned DefRstCycles     = 2;
    localparam int unsigned DefTimeoutCycles = 65536;
    localparam int unsigned DefCntW          = 32;

endpackage

// File: rtl/rsa_run_counter.sv
// Saturating up-counter with synchronous clear and a terminal-value match flag.
module rsa_run_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             match_o
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign match_o = (cnt_q == term_i);

endmodule

// File: rtl/rsa_run_controller.sv
// Drives the CPU reset/start handshake for one run per host go and reports the outcome.
module rsa_run_controller
    import rsa_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = DefRstCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
    parameter int unsigned CNT_W          = DefCntW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             go_i,
    input  logic             abort_i,
    input  logic             end_flag_i,
    input  logic             flag_zero_i,
    output logic             cpu_reset_o,
    output logic             cpu_start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_err_o,
    output logic             zero_result_o,
    output logic [CNT_W-1:0] run_cycles_o
);

    if (RST_CYCLES < 1 || TIMEOUT_CYCLES < 2 ||
        (CNT_W < 32 && TIMEOUT_CYCLES >= (32'd1 << CNT_W))) begin : gen_param_check
        $error("rsa_run_controller: illegal RST_CYCLES/TIMEOUT_CYCLES/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] RstTerm = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TmoTerm = CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_t       state_q, state_d;
    logic             end_prev_q;
    logic             cpu_reset_q, cpu_start_q, busy_q, done_q;
    logic             timeout_err_q, zero_result_q;
    logic [CNT_W-1:0] run_cycles_q;

    logic             cnt_clr, cnt_en, cnt_match;
    logic [CNT_W-1:0] cnt_term, cnt_val;
    logic             end_rise, go_accept, tmo_hit, end_capture;

    // Reset value of end_prev_q is 1 so a level already high is never seen as an edge.
    assign end_rise = end_flag_i & ~end_prev_q;

    rsa_run_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .cnt_o  (cnt_val),
        .match_o(cnt_match)
    );

    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        cnt_term    = TmoTerm;
        go_accept   = 1'b0;
        tmo_hit     = 1'b0;
        end_capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go_i) begin
                    state_d   = HOLD_RST;
                    cnt_clr   = 1'b1;
                    go_accept = 1'b1;
                end
            end
            HOLD_RST, ABORT_RST: begin
                cnt_term = RstTerm;
                if (abort_i) begin
                    state_d = ABORT_RST;
                    cnt_clr = 1'b1;
                end else if (cnt_match) begin
                    state_d = (state_q == HOLD_RST) ? ARM : IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ARM: begin
                cnt_clr = 1'b1;
                state_d = abort_i ? ABORT_RST : WAIT_END;
            end
            WAIT_END: begin
                // Priority: abort, then completion, then timeout.
                if (abort_i) begin
                    state_d = ABORT_RST;
                    cnt_clr = 1'b1;
                end else if (end_rise) begin
                    state_d     = DONE;
                    end_capture = 1'b1;
                end else if (cnt_match) begin
                    state_d = IDLE;
                    tmo_hit = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_d = abort_i ? ABORT_RST : IDLE;
                cnt_clr = abort_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            end_prev_q    <= 1'b1;
            cpu_reset_q   <= 1'b1;
            cpu_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            zero_result_q <= 1'b0;
            run_cycles_q  <= '0;
        end else begin
            state_q     <= state_d;
            end_prev_q  <= end_flag_i;
            cpu_reset_q <= (state_d == HOLD_RST) || (state_d == ABORT_RST);
            cpu_start_q <= (state_d == WAIT_END);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            if (go_accept) begin
                timeout_err_q <= 1'b0;
            end else if (tmo_hit) begin
                timeout_err_q <= 1'b1;
            end
            if (end_capture) begin
                run_cycles_q  <= cnt_val;
                zero_result_q <= flag_zero_i;
            end
        end
    end

    assign cpu_reset_o   = cpu_reset_q;
    assign cpu_start_o   = cpu_start_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_err_o = timeout_err_q;
    assign zero_result_o = zero_result_q;
    assign run_cycles_o  = run_cycles_q;

endmodule
